player_executor: RTL and testbench
==================================

Name: player_executor

Overview:
- Execution end of the player-instruction interface driven by the game state machine.
- Decodes the 16-bit instruction word {op[15:12], arg[11:4], 4'b0000} qualified by isMove / startDmg.
- Maintains player HP and arena position, and reports death back to the state machine.
- Feeds the renderer (playerX/playerY) and the HP bar (playerHP).

Parameters:
MAX_HP, 100, HP ceiling; value after reset.
ARENA_X0, 220, left arena bound in pixels (inclusive).
ARENA_X1, 420, right arena bound in pixels (exclusive).
ARENA_Y0, 240, top arena bound in pixels (inclusive).
ARENA_Y1, 400, bottom arena bound in pixels (exclusive).
PLAYER_SIZE, 16, player sprite edge in pixels.
MOVE_DIV, 250000, clk cycles between successive 1-step moves while a move is held.
INVULN_CYCLES, 50000000, clk cycles of damage immunity after an accepted HPY/DPY.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
playerInstruction  input  16  {op, arg, 4'b0}; op HPY=1 DPY=2 IDG=3 SDG=4 MOV=5 SHP=6, others NOP
isMove  input  1  qualifies MOV, held high while a key is held
startDmg  input  1  qualifies HPY/DPY, may stay high for many cycles
playerX  output  10  player top-left X
playerY  output  10  player top-left Y
playerHP  output  8  current HP
isDeath  output  1  high while HP==0 (state DEAD)
dmgDone  output  1  1-cycle pulse when an HPY/DPY is applied
invuln  output  1  high during the immunity window (renderer blinks sprite)

Behaviour:
- Reset values:
  - playerHP=MAX_HP
  - playerX=CX=(ARENA_X0+ARENA_X1-PLAYER_SIZE)/2, playerY=CY=(ARENA_Y0+ARENA_Y1-PLAYER_SIZE)/2
  - step=1, isDeath=0, dmgDone=0, invuln=0, move counter=0, FSM=ALIVE
- Reset has priority over everything, including mid-immunity and DEAD.
- FSM states: ALIVE, INVULN, DEAD. All decode happens on the registered clk edge; outputs update 1 cycle after the qualifying input.
- ALIVE, startDmg=1:
  - DPY: HP = (HP>arg) ? HP-arg : 0.
  - HPY: HP = min(HP+arg, MAX_HP), computed 9 bits wide.
  - Either: dmgDone pulses 1 cycle, immunity counter loads INVULN_CYCLES-1. Go to DEAD if resulting HP==0, else INVULN.
  - arg=0 is still accepted: dmgDone pulses and immunity starts.
- INVULN:
  - startDmg/HPY/DPY ignored; invuln=1.
  - Counter decrements each clk; at 0, return to ALIVE (invuln low the same cycle).
- MOV, isMove=1, state ALIVE or INVULN:
  - Move counter increments each cycle. When it reaches MOVE_DIV-1 it wraps to 0 and the player moves step pixels in direction arg[1:0]: 0 up (Y-), 1 left (X-), 2 down (Y+), 3 right (X+).
  - Result clamps to X in [ARENA_X0, ARENA_X1-PLAYER_SIZE], Y in [ARENA_Y0, ARENA_Y1-PLAYER_SIZE]. No wrap-around.
  - isMove=0 or op!=MOV clears the move counter. The first step of a new press occurs MOVE_DIV cycles after isMove rises.
- IDG (any non-DEAD state, no qualifier, level-sensitive): position set to CX/CY, move counter cleared. HP and immunity unchanged.
- SDG (no qualifier): step=arg[3:0]. arg=0 is coerced to 1.
- SHP, startDmg=1, any state including DEAD: HP = min(arg, MAX_HP); immunity cleared. Next state ALIVE if arg!=0, else DEAD.
- DEAD:
  - isDeath=1. MOV/HPY/DPY/IDG ignored. Position frozen.
  - Exit only via reset or SHP with arg!=0.
- Simultaneous events:
  - A qualified HPY/DPY and isMove in the same cycle: the op field selects which is executed; the other is ignored.
  - HP reaching 0 takes effect the same cycle as dmgDone; isDeath rises on the following edge together with the HP update.
- Undefined op codes (0, 7-15) are NOPs and do not disturb counters, except clearing the move counter.

Test Plan:
- Reset, then idle 10 cycles -> HP=100, X=312, Y=312, isDeath=0, invuln=0.
- DPY arg=30 with startDmg held 5 cycles -> exactly one dmgDone pulse; HP=70; invuln=1 for INVULN_CYCLES (bench uses INVULN_CYCLES=20); a second DPY during the window is ignored.
- HP=95, HPY arg=10 after immunity expires -> HP=100 (saturate). Then DPY arg=200 -> HP=0, isDeath=1; later MOV/DPY ignored; SHP arg=50 -> HP=50, isDeath=0.
- MOV right held with MOVE_DIV=4, SDG arg=5 -> X advances 5 every 4 cycles and clamps at 404; MOV up clamps Y at 240; releasing isMove stops movement within 1 cycle.
- Reset asserted mid-immunity and mid-move -> next cycle all outputs at reset values, FSM=ALIVE.
- IDG after moving to the corner -> X=312, Y=312 next cycle, HP unchanged.

Source files
------------

// File: rtl/player_executor.sv
// player_executor: decodes player instructions; tracks HP, arena position and damage immunity; reports death.
// Ports: clk/reset (sync, active-high); playerInstruction {op,arg,4'b0}; isMove qualifies MOV;
// startDmg qualifies HPY/DPY/SHP; playerX/playerY top-left sprite position; playerHP current HP;
// isDeath high in DEAD; dmgDone 1-cycle pulse per applied HPY/DPY; invuln high during immunity.
module player_executor #(
  parameter int MAX_HP        = 100,
  parameter int ARENA_X0      = 220,
  parameter int ARENA_X1      = 420,
  parameter int ARENA_Y0      = 240,
  parameter int ARENA_Y1      = 400,
  parameter int PLAYER_SIZE   = 16,
  parameter int MOVE_DIV      = 250000,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] playerInstruction,
  input  logic        isMove,
  input  logic        startDmg,
  output logic [9:0]  playerX,
  output logic [9:0]  playerY,
  output logic [7:0]  playerHP,
  output logic        isDeath,
  output logic        dmgDone,
  output logic        invuln
);
  localparam int IW = $clog2(INVULN_CYCLES + 1);
  localparam int MW = $clog2(MOVE_DIV + 1);
  localparam logic [9:0]  XC  = 10'((ARENA_X0 + ARENA_X1 - PLAYER_SIZE) / 2);
  localparam logic [9:0]  YC  = 10'((ARENA_Y0 + ARENA_Y1 - PLAYER_SIZE) / 2);
  localparam logic [10:0] XLO = 11'(ARENA_X0);
  localparam logic [10:0] XHI = 11'(ARENA_X1 - PLAYER_SIZE);
  localparam logic [10:0] YLO = 11'(ARENA_Y0);
  localparam logic [10:0] YHI = 11'(ARENA_Y1 - PLAYER_SIZE);
  localparam logic [7:0]  HPM = 8'(MAX_HP);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
  state_t        state_q, state_d;
  logic [7:0]    hp_q, hp_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    step_q, step_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          dmg_q;
  logic [3:0]    op;
  logic [7:0]    arg;
  logic [8:0]    hp_sum;
  logic [10:0]   xl, xr, yu, yd;
  logic          acc_dmg, shp, idg, mov, step_now;
  logic          unused_low;
  assign op         = playerInstruction[15:12];
  assign arg        = playerInstruction[11:4];
  assign unused_low = ^playerInstruction[3:0];
  assign hp_sum     = {1'b0, hp_q} + {1'b0, arg};
  assign acc_dmg    = startDmg && state_q == ALIVE && (op == 4'd1 || op == 4'd2);
  assign shp        = startDmg && op == 4'd6;
  assign idg        = op == 4'd3 && state_q != DEAD;
  assign mov        = isMove && op == 4'd5 && state_q != DEAD;
  assign step_now   = mov && mcnt_q == MW'(MOVE_DIV - 1);
  // Clamped candidates for each direction; 11 bits so X+step/Y+step cannot overflow before the clamp.
  assign xl = ({1'b0, x_q} - {7'd0, step_q}) < XLO ? XLO : {1'b0, x_q} - {7'd0, step_q};
  assign xr = ({1'b0, x_q} + {7'd0, step_q}) > XHI ? XHI : {1'b0, x_q} + {7'd0, step_q};
  assign yu = ({1'b0, y_q} - {7'd0, step_q}) < YLO ? YLO : {1'b0, y_q} - {7'd0, step_q};
  assign yd = ({1'b0, y_q} + {7'd0, step_q}) > YHI ? YHI : {1'b0, y_q} + {7'd0, step_q};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALIVE;
      hp_q    <= HPM;
      x_q     <= XC;
      y_q     <= YC;
      step_q  <= 4'd1;
      icnt_q  <= '0;
      mcnt_q  <= '0;
      dmg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      icnt_q  <= icnt_d;
      mcnt_q  <= mcnt_d;
      dmg_q   <= acc_dmg;
    end
  end
  // Next state: SHP overrides everything, then an accepted hit/heal, then the immunity countdown.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    if (shp) begin
      state_d = arg != 8'd0 ? ALIVE : DEAD;
      icnt_d  = '0;
    end else if (acc_dmg) begin
      state_d = hp_d == 8'd0 ? DEAD : INVULN;
      icnt_d  = IW'(INVULN_CYCLES - 1);
    end else if (state_q == INVULN) begin
      state_d = icnt_q == '0 ? ALIVE : INVULN;
      icnt_d  = icnt_q == '0 ? '0 : icnt_q - 1'b1;
    end
  end
  always_comb begin
    hp_d   = shp ? (arg > HPM ? HPM : arg) :
             !acc_dmg ? hp_q :
             op == 4'd1 ? (hp_sum > {1'b0, HPM} ? HPM : hp_sum[7:0]) :
             (hp_q > arg ? hp_q - arg : 8'd0);
    mcnt_d = mov && !step_now ? mcnt_q + 1'b1 : '0;
    x_d    = idg ? XC : !step_now ? x_q : arg[1:0] == 2'd1 ? xl[9:0] : arg[1:0] == 2'd3 ? xr[9:0] : x_q;
    y_d    = idg ? YC : !step_now ? y_q : arg[1:0] == 2'd0 ? yu[9:0] : arg[1:0] == 2'd2 ? yd[9:0] : y_q;
    step_d = op != 4'd4 ? step_q : arg[3:0] == 4'd0 ? 4'd1 : arg[3:0];
  end
  always_comb begin
    playerX  = x_q;
    playerY  = y_q;
    playerHP = hp_q;
    isDeath  = state_q == DEAD;
    invuln   = state_q == INVULN;
    dmgDone  = dmg_q;
  end
endmodule

// File: tb/tb_player_executor.sv
// tb_player_executor: directed self-checking bench for player_executor (MOVE_DIV=4, INVULN_CYCLES=20).
module tb_player_executor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        is_move = 1'b0;
  logic        start_dmg = 1'b0;
  logic [9:0]  px, py;
  logic [7:0]  hp;
  logic        is_death, dmg_done, invuln;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses;

  player_executor #(.MOVE_DIV(4), .INVULN_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .playerInstruction(instr), .isMove(is_move), .startDmg(start_dmg),
    .playerX(px), .playerY(py), .playerHP(hp), .isDeath(is_death), .dmgDone(dmg_done), .invuln(invuln)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] arg);
    return {op, arg, 4'b0000};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step(10);
    chk("rst_hp", hp, 100);
    chk("rst_x", px, 312);
    chk("rst_y", py, 312);
    chk("rst_death", is_death, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_dmg", dmg_done, 0);
    // DPY 30 held 5 cycles: one pulse, then immune
    instr = ins(4'd2, 8'd30);
    start_dmg = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      pulses += int'(dmg_done);
      if (i == 0) begin
        chk("dpy_pulse", dmg_done, 1);
        chk("dpy_hp", hp, 70);
        chk("dpy_invuln", invuln, 1);
      end
    end
    chk("dpy_one_pulse", pulses, 1);
    instr = ins(4'd2, 8'd10);
    step(2);
    chk("inv_ignore_hp", hp, 70);
    chk("inv_ignore_dmg", dmg_done, 0);
    start_dmg = 1'b0;
    instr = '0;
    step(13);
    chk("inv_last", invuln, 1);
    step(1);
    chk("inv_end", invuln, 0);
    // heal saturation, then death
    instr = ins(4'd6, 8'd95);
    start_dmg = 1'b1;
    step(1);
    chk("shp95_hp", hp, 95);
    instr = ins(4'd1, 8'd10);
    step(1);
    chk("hpy_sat", hp, 100);
    chk("hpy_pulse", dmg_done, 1);
    start_dmg = 1'b0;
    step(21);
    chk("hpy_inv_end", invuln, 0);
    instr = ins(4'd2, 8'd200);
    start_dmg = 1'b1;
    step(1);
    chk("kill_hp", hp, 0);
    chk("kill_death", is_death, 1);
    chk("kill_pulse", dmg_done, 1);
    start_dmg = 1'b0;
    instr = ins(4'd5, 8'd3);
    is_move = 1'b1;
    step(10);
    chk("dead_mov_x", px, 312);
    is_move = 1'b0;
    instr = ins(4'd1, 8'd50);
    start_dmg = 1'b1;
    step(2);
    chk("dead_hpy_hp", hp, 0);
    chk("dead_hpy_dmg", dmg_done, 0);
    instr = ins(4'd6, 8'd50);
    step(1);
    chk("revive_hp", hp, 50);
    chk("revive_death", is_death, 0);
    start_dmg = 1'b0;
    // movement with step 5, MOVE_DIV 4
    instr = ins(4'd4, 8'd5);
    step(1);
    instr = ins(4'd5, 8'd3);
    is_move = 1'b1;
    step(3);
    chk("mov_before", px, 312);
    step(1);
    chk("mov_first", px, 317);
    step(4);
    chk("mov_second", px, 322);
    step(100);
    chk("mov_clamp_x", px, 404);
    instr = ins(4'd5, 8'd0);
    step(100);
    chk("mov_clamp_y", py, 240);
    instr = ins(4'd5, 8'd2);
    step(4);
    chk("mov_down", py, 245);
    step(3);
    is_move = 1'b0;
    step(1);
    chk("release_stop", py, 245);
    step(5);
    chk("release_hold", py, 245);
    is_move = 1'b1;
    step(3);
    chk("repress_wait", py, 245);
    step(1);
    chk("repress_move", py, 250);
    instr = ins(4'd5, 8'd0);
    step(8);
    chk("corner_x", px, 404);
    chk("corner_y", py, 240);
    is_move = 1'b0;
    instr = ins(4'd3, 8'd0);
    step(1);
    chk("idg_x", px, 312);
    chk("idg_y", py, 312);
    chk("idg_hp", hp, 50);
    // reset mid-immunity and mid-move
    instr = ins(4'd2, 8'd10);
    start_dmg = 1'b1;
    step(1);
    chk("pre_rst_hp", hp, 40);
    start_dmg = 1'b0;
    instr = ins(4'd5, 8'd3);
    is_move = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    chk("mid_rst_hp", hp, 100);
    chk("mid_rst_x", px, 312);
    chk("mid_rst_invuln", invuln, 0);
    chk("mid_rst_death", is_death, 0);
    reset = 1'b0;
    step(3);
    chk("post_rst_wait", px, 312);
    step(1);
    chk("post_rst_step1", px, 313);
    is_move = 1'b0;
    // SHP boundaries: 0 kills, large value saturates
    instr = ins(4'd6, 8'd0);
    start_dmg = 1'b1;
    step(1);
    chk("shp0_hp", hp, 0);
    chk("shp0_death", is_death, 1);
    instr = ins(4'd6, 8'd250);
    step(1);
    chk("shp_sat_hp", hp, 100);
    chk("shp_sat_death", is_death, 0);
    start_dmg = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
